// File: rtl/pac_flash_writer.sv
// pac_flash_writer: erases the flash save area, then programs the SDRAM PAC image into it page by page.
// Optional build macro PAC_WRITE_TIMEOUT_EN bounds each status poll loop to POLL_LIMIT reads.
module pac_flash_writer #(
    parameter logic [23:0] RAM_BASE    = 24'h77_E000,
    parameter logic [23:0] FLASH_BASE  = 24'h1F_0000,
    parameter int          IMAGE_BYTES = 8192,
    parameter logic [23:0] POLL_LIMIT  = 24'd4_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        ram_req,
    output logic [23:0] ram_addr,
    input  logic        ram_ack,
    input  logic [7:0]  ram_rdata,
    output logic        fl_req,
    output logic [1:0]  fl_op,
    output logic [23:0] fl_addr,
    output logic        fl_wvalid,
    output logic [7:0]  fl_wdata,
    input  logic        fl_wready,
    input  logic        fl_done,
    input  logic [7:0]  fl_status
);

    localparam int OFF_W = $clog2(IMAGE_BYTES) + 1;
    localparam int SEC_W = $clog2(IMAGE_BYTES / 4096) + 1;
    localparam logic [OFF_W-1:0] IMG_END  = OFF_W'(IMAGE_BYTES);
    localparam logic [OFF_W-1:0] PAGE_OFF = OFF_W'(256);
    localparam logic [SEC_W-1:0] SEC_END  = SEC_W'(IMAGE_BYTES / 4096);
    localparam logic [8:0]       PAGE_LEN = 9'd256;

    localparam logic [1:0] OP_WREN  = 2'd0;
    localparam logic [1:0] OP_ERASE = 2'd1;
    localparam logic [1:0] OP_PROG  = 2'd2;
    localparam logic [1:0] OP_RDSR  = 2'd3;

    typedef enum logic [3:0] {
        IDLE, ERASE_WREN, ERASE, ERASE_POLL,
        PROG_WREN, PROG, PROG_POLL, FINISH, FAIL
    } state_e;

    state_e             state_q, state_d;
    logic [SEC_W-1:0]   sector_q, sector_d;
    logic [OFF_W-1:0]   offset_q, offset_d;
    logic [8:0]         bcnt_q, bcnt_d;
    logic               ram_req_q, ram_req_d;
    logic [23:0]        ram_addr_q, ram_addr_d;
    logic               fl_wvalid_q, fl_wvalid_d;
    logic [7:0]         fl_wdata_q, fl_wdata_d;
    logic               poll_expired;
    logic               unused_ok;

`ifdef PAC_WRITE_TIMEOUT_EN
    logic [23:0] poll_q, poll_d;
    logic [23:0] poll_inc;
    logic        error_q, error_d;

    assign poll_inc     = poll_q + 24'd1;
    assign poll_expired = fl_status[0] && (poll_inc >= POLL_LIMIT);
    assign error        = error_q;
    assign unused_ok    = ^fl_status[7:1];

    always_comb begin
        poll_d  = poll_q;
        error_d = error_q;
        if (state_q == IDLE && start) error_d = 1'b0;
        if (state_d == FAIL && state_q != FAIL) error_d = 1'b1;
        if ((state_q == ERASE && state_d == ERASE_POLL) ||
            (state_q == PROG && state_d == PROG_POLL)) begin
            poll_d = '0;
        end else if ((state_q == ERASE_POLL || state_q == PROG_POLL) && fl_done) begin
            poll_d = poll_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            poll_q  <= '0;
            error_q <= 1'b0;
        end else begin
            poll_q  <= poll_d;
            error_q <= error_d;
        end
    end
`else
    assign poll_expired = 1'b0;
    assign error        = 1'b0;
    assign unused_ok    = ^{fl_status[7:1], POLL_LIMIT};
`endif

    always_comb begin
        state_d     = state_q;
        sector_d    = sector_q;
        offset_d    = offset_q;
        bcnt_d      = bcnt_q;
        ram_req_d   = ram_req_q;
        ram_addr_d  = ram_addr_q;
        fl_wvalid_d = fl_wvalid_q;
        fl_wdata_d  = fl_wdata_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = ERASE_WREN;
                    sector_d = '0;
                    offset_d = '0;
                end
            end
            ERASE_WREN: if (fl_done) state_d = ERASE;
            ERASE:      if (fl_done) state_d = ERASE_POLL;
            ERASE_POLL: begin
                if (fl_done && !fl_status[0]) begin
                    sector_d = sector_q + 1'b1;
                    if (sector_d < SEC_END) begin
                        state_d = ERASE_WREN;
                    end else begin
                        offset_d = '0;
                        state_d  = PROG_WREN;
                    end
                end else if (fl_done && poll_expired) begin
                    state_d = FAIL;
                end
            end
            PROG_WREN: begin
                if (fl_done) begin
                    state_d    = PROG;
                    bcnt_d     = '0;
                    ram_req_d  = 1'b1;
                    ram_addr_d = RAM_BASE + 24'(offset_q);
                end
            end
            PROG: begin
                if (ram_req_q && ram_ack) begin
                    ram_req_d   = 1'b0;
                    fl_wvalid_d = 1'b1;
                    fl_wdata_d  = ram_rdata;
                end
                // next read starts only after this byte is handed over
                if (fl_wvalid_q && fl_wready) begin
                    fl_wvalid_d = 1'b0;
                    bcnt_d      = bcnt_q + 9'd1;
                    if (bcnt_d != PAGE_LEN) begin
                        ram_req_d  = 1'b1;
                        ram_addr_d = RAM_BASE + 24'(offset_q) + 24'(bcnt_d);
                    end
                end
                if (fl_done && bcnt_q == PAGE_LEN) state_d = PROG_POLL;
            end
            PROG_POLL: begin
                if (fl_done && !fl_status[0]) begin
                    offset_d = offset_q + PAGE_OFF;
                    state_d  = (offset_d < IMG_END) ? PROG_WREN : FINISH;
                end else if (fl_done && poll_expired) begin
                    state_d = FAIL;
                end
            end
            FINISH:  state_d = IDLE;
            FAIL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fl_req  = 1'b0;
        fl_op   = OP_WREN;
        fl_addr = '0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            ERASE_WREN, PROG_WREN: begin
                fl_req = 1'b1;
                busy   = 1'b1;
            end
            ERASE: begin
                fl_req  = 1'b1;
                busy    = 1'b1;
                fl_op   = OP_ERASE;
                fl_addr = FLASH_BASE + (24'(sector_q) << 12);
            end
            PROG: begin
                fl_req  = 1'b1;
                busy    = 1'b1;
                fl_op   = OP_PROG;
                fl_addr = FLASH_BASE + 24'(offset_q);
            end
            ERASE_POLL, PROG_POLL: begin
                fl_req = 1'b1;
                busy   = 1'b1;
                fl_op  = OP_RDSR;
            end
            FINISH:  done = 1'b1;
            default: ;
        endcase
    end

    assign ram_req   = ram_req_q;
    assign ram_addr  = ram_addr_q;
    assign fl_wvalid = fl_wvalid_q;
    assign fl_wdata  = fl_wdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sector_q    <= '0;
            offset_q    <= '0;
            bcnt_q      <= '0;
            ram_req_q   <= 1'b0;
            ram_addr_q  <= '0;
            fl_wvalid_q <= 1'b0;
            fl_wdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            sector_q    <= sector_d;
            offset_q    <= offset_d;
            bcnt_q      <= bcnt_d;
            ram_req_q   <= ram_req_d;
            ram_addr_q  <= ram_addr_d;
            fl_wvalid_q <= fl_wvalid_d;
            fl_wdata_q  <= fl_wdata_d;
        end
    end

endmodule

// File: tb/tb_pac_flash_writer.sv
// Bench for pac_flash_writer: SDRAM and flash-controller models plus
// an op-sequence and image reference built from the save procedure.
`timescale 1ns/1ps
module tb_pac_flash_writer;

    localparam logic [23:0] RB = 24'h77_E000;
    localparam logic [23:0] FB = 24'h1F_0000;
    localparam int NB = 8192;
    localparam int NPH = 34;

    logic clk = 1'b0;
    logic reset, start;
    logic busy, done, error;
    logic ram_req, ram_ack;
    logic [23:0] ram_addr;
    logic [7:0] ram_rdata;
    logic fl_req, fl_wvalid, fl_wready, fl_done;
    logic [1:0] fl_op;
    logic [23:0] fl_addr;
    logic [7:0] fl_wdata, fl_status;

    always #5 clk = ~clk;

    pac_flash_writer #(.POLL_LIMIT(24'd10)) dut (
        .clk(clk), .reset(reset), .start(start),
        .busy(busy), .done(done), .error(error),
        .ram_req(ram_req), .ram_addr(ram_addr),
        .ram_ack(ram_ack), .ram_rdata(ram_rdata),
        .fl_req(fl_req), .fl_op(fl_op), .fl_addr(fl_addr),
        .fl_wvalid(fl_wvalid), .fl_wdata(fl_wdata),
        .fl_wready(fl_wready), .fl_done(fl_done),
        .fl_status(fl_status)
    );

    logic [7:0]  mem [NB];
    logic [7:0]  flash [NB];
    int          busy_n [NPH];
    logic [25:0] obs_ops [$];
    logic [25:0] exp_ops [$];

    bit rnd, spur_en, stuck;
    int ack_fix, wr_fix;
    int ph, rd_in_ph, prog_ops, cur_byte;
    int rd_cnt, overlap, hold_err, done_cnt, done_busy_err;
    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ram_at(input logic [23:0] a);
        logic [23:0] idx;
        idx = a - RB;
        return (idx < 24'(NB)) ? mem[idx] : 8'hEE;
    endfunction

    // SDRAM model: ack after a per-byte delay, junk data otherwise
    initial begin
        int rc, dly;
        rc = 0;
        dly = 0;
        ram_ack = 1'b0;
        ram_rdata = 8'h00;
        forever begin
            @(negedge clk);
            ram_ack = 1'b0;
            ram_rdata = 8'($urandom);
            if (reset) begin
                rc = 0;
            end else if (ram_req) begin
                if (rc >= dly) begin
                    ram_ack = 1'b1;
                    ram_rdata = ram_at(ram_addr);
                    rd_cnt++;
                    rc = 0;
                    dly = rnd ? int'($urandom_range(0, 1)) : ack_fix;
                end else begin
                    rc++;
                end
            end
        end
    end

    // Flash controller model
    initial begin
        bit cb, spd;
        logic [1:0] cop;
        logic [23:0] cad, fa;
        int cw, nb, wc, wd;
        cb = 0; spd = 0; cop = 0; cad = 0;
        cw = 0; nb = 0; wc = 0; wd = 0;
        fl_done = 1'b0;
        fl_status = 8'h00;
        fl_wready = 1'b0;
        forever begin
            @(negedge clk);
            fl_done = 1'b0;
            fl_status = 8'h00;
            fl_wready = 1'b0;
            if (reset) begin
                cb = 0;
            end else begin
                if (!cb && fl_req) begin
                    cb = 1;
                    cop = fl_op;
                    cad = (fl_op == 2'd1 || fl_op == 2'd2) ? fl_addr : 24'h0;
                    obs_ops.push_back({cop, cad});
                    cw = rnd ? int'($urandom_range(0, 2)) : 0;
                    nb = 0; wc = 0; spd = 0;
                    wd = rnd ? int'($urandom_range(0, 1)) : wr_fix;
                    if (cop == 2'd2) prog_ops++;
                end
                if (cb) begin
                    if (!fl_req || fl_op != cop ||
                        ((cop == 2'd1 || cop == 2'd2) && fl_addr != cad))
                        hold_err++;
                    if (cop == 2'd2) begin
                        cur_byte = nb;
                        if (nb == 256) begin
                            fl_done = 1'b1;
                            cb = 0;
                        end else begin
                            if (fl_wvalid) begin
                                if (wc >= wd) begin
                                    fl_wready = 1'b1;
                                    fa = cad + 24'(nb) - FB;
                                    if (fa < 24'(NB)) flash[fa] = fl_wdata;
                                    nb++;
                                    wc = 0;
                                    wd = rnd ? int'($urandom_range(0, 1)) : wr_fix;
                                end else begin
                                    wc++;
                                end
                            end
                            if (spur_en && nb == 10 && !spd) begin
                                fl_done = 1'b1;
                                spd = 1;
                            end
                        end
                    end else if (cw == 0) begin
                        fl_done = 1'b1;
                        cb = 0;
                        if (cop == 2'd3) begin
                            if (stuck) begin
                                fl_status = 8'h01;
                            end else if (ph < NPH && rd_in_ph < busy_n[ph]) begin
                                fl_status = 8'h01;
                                rd_in_ph++;
                            end else begin
                                fl_status = 8'($urandom) & 8'hFE;
                                ph++;
                                rd_in_ph = 0;
                            end
                        end
                    end else begin
                        cw--;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (ram_req && fl_wvalid) overlap++;
            if (done) begin
                done_cnt++;
                if (busy) done_busy_err++;
            end
        end
    end

    task automatic clear_model();
        obs_ops.delete();
        ph = 0; rd_in_ph = 0; prog_ops = 0; cur_byte = 0;
        rd_cnt = 0; overlap = 0; hold_err = 0;
        done_cnt = 0; done_busy_err = 0; stuck = 0;
        for (int i = 0; i < NB; i++) begin
            mem[i] = 8'($urandom);
            flash[i] = 8'hFF;
        end
    endtask

    // expected op stream: per sector WREN, ERASE, polls; per page WREN, PROG, polls
    task automatic build_exp();
        exp_ops.delete();
        for (int s = 0; s < NB / 4096; s++) begin
            exp_ops.push_back({2'd0, 24'h0});
            exp_ops.push_back({2'd1, FB + 24'(s * 4096)});
            for (int k = 0; k <= busy_n[s]; k++) exp_ops.push_back({2'd3, 24'h0});
        end
        for (int p = 0; p < NB / 256; p++) begin
            exp_ops.push_back({2'd0, 24'h0});
            exp_ops.push_back({2'd2, FB + 24'(p * 256)});
            for (int k = 0; k <= busy_n[2 + p]; k++) exp_ops.push_back({2'd3, 24'h0});
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int lim);
        int i;
        i = 0;
        while (busy && i < lim) begin
            @(negedge clk);
            i++;
        end
        check(tag, 64'(busy), 64'(0));
        repeat (2) @(negedge clk);
    endtask

    task automatic cmp_seq(input string tag);
        int bad;
        bad = 0;
        check({tag, "_len"}, 64'(obs_ops.size()), 64'(exp_ops.size()));
        for (int i = 0; i < obs_ops.size() && i < exp_ops.size(); i++)
            if (obs_ops[i] !== exp_ops[i]) bad++;
        check({tag, "_ops"}, 64'(bad), 64'(0));
    endtask

    task automatic cmp_image(input string tag, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) if (flash[i] !== mem[i]) bad++;
        check(tag, 64'(bad), 64'(0));
    endtask

    function automatic int count_op(input logic [1:0] op);
        int c;
        c = 0;
        foreach (obs_ops[i]) if (obs_ops[i][25:24] == op) c++;
        return c;
    endfunction

    initial begin
        int k, lim;
        reset = 1'b1;
        start = 1'b0;
        rnd = 0; spur_en = 0; stuck = 0;
        ack_fix = 0; wr_fix = 0;
        for (int i = 0; i < NPH; i++) busy_n[i] = 0;
        clear_model();
        repeat (3) @(negedge clk);
        check("rst_outs", {busy, done, error, ram_req, fl_req, fl_wvalid,
                           ram_addr, fl_addr, fl_op, fl_wdata}, 64'(0));
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", 64'(busy), 64'(0));

        // full save, fast handshakes, 3 busy polls after first erase,
        // early fl_done during each page, extra starts while busy
        clear_model();
        busy_n[0] = 3;
        spur_en = 1;
        build_exp();
        pulse_start();
        check("busy_after_start", 64'(busy), 64'(1));
        repeat (20) @(negedge clk);
        pulse_start();
        repeat (3000) @(negedge clk);
        pulse_start();
        wait_idle("a_timeout", 40000);
        cmp_seq("a_seq");
        check("a_erase_cnt", 64'(count_op(2'd1)), 64'(2));
        check("a_prog_cnt", 64'(count_op(2'd2)), 64'(32));
        k = 2;
        while (k < obs_ops.size() && obs_ops[k][25:24] == 2'd3) k++;
        check("a_rdsr_first", 64'(k - 2), 64'(4));
        check("a_wren_after",
              (k < obs_ops.size()) ? 64'(obs_ops[k][25:24]) : 64'hDEAD, 64'(0));
        cmp_image("a_image", NB);
        check("a_reads", 64'(rd_cnt), 64'(NB));
        check("a_done_cnt", 64'(done_cnt), 64'(1));
        check("a_done_busy", 64'(done_busy_err), 64'(0));
        check("a_overlap", 64'(overlap), 64'(0));
        check("a_hold", 64'(hold_err), 64'(0));
        check("a_error", 64'(error), 64'(0));

        // slow handshakes, then reset during page 5 byte 100
        clear_model();
        spur_en = 0;
        ack_fix = 3;
        wr_fix = 5;
        for (int i = 0; i < NPH; i++) busy_n[i] = int'($urandom_range(0, 2));
        pulse_start();
        lim = 0;
        while (!(prog_ops == 6 && cur_byte >= 100) && lim < 30000) begin
            @(negedge clk);
            lim++;
        end
        check("b_reach_p5", 64'(lim < 30000), 64'(1));
        reset = 1'b1;
        @(negedge clk);
        check("b_rst_outs", {busy, done, error, ram_req, fl_req, fl_wvalid,
                             ram_addr, fl_addr, fl_op, fl_wdata}, 64'(0));
        reset = 1'b0;
        cmp_image("b_pages0_4", 5 * 256);
        check("b_overlap", 64'(overlap), 64'(0));
        check("b_hold", 64'(hold_err), 64'(0));
        repeat (5) @(negedge clk);
        check("b_quiet", {ram_req, fl_req, fl_wvalid, busy}, 64'(0));

        // restart after abort with randomized handshakes and polls
        clear_model();
        rnd = 1;
        for (int i = 0; i < NPH; i++) busy_n[i] = int'($urandom_range(0, 2));
        build_exp();
        pulse_start();
        lim = 0;
        while (obs_ops.size() < 2 && lim < 50) begin
            @(negedge clk);
            lim++;
        end
        check("c_first_wren", (obs_ops.size() > 0) ? 64'(obs_ops[0]) : 64'hDEAD,
              64'({2'd0, 24'h0}));
        check("c_first_erase", (obs_ops.size() > 1) ? 64'(obs_ops[1]) : 64'hDEAD,
              64'({2'd1, FB}));
        wait_idle("c_timeout", 45000);
        cmp_seq("c_seq");
        cmp_image("c_image", NB);
        check("c_done_cnt", 64'(done_cnt), 64'(1));
        check("c_overlap", 64'(overlap), 64'(0));
        check("c_error", 64'(error), 64'(0));

`ifdef PAC_WRITE_TIMEOUT_EN
        // WIP stuck high: ten status reads then failure
        clear_model();
        rnd = 0;
        stuck = 1;
        pulse_start();
        wait_idle("t_timeout", 2000);
        check("t_error", 64'(error), 64'(1));
        check("t_done_cnt", 64'(done_cnt), 64'(0));
        check("t_rdsr_cnt", 64'(count_op(2'd3)), 64'(10));
        check("t_ops", 64'(obs_ops.size()), 64'(12));
        stuck = 0;
        pulse_start();
        check("t_err_clr", 64'(error), 64'(0));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
